dcache_access_master: RTL and testbench
=======================================

Name: dcache_access_master

Overview:
- Load/store requester that drives the data-cache port: word address, 4-bit byte write enables, write data; consumes the registered read data.
- Sits between the core's MEM stage and the data cache.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into lane-aligned cache accesses.
- Returns sign/zero-extended load data, or an error flag, over a valid/ready response handshake.

Parameters:
- ADDR_VALID_BITS, 14, byte-address width the cache decodes; req_addr[31:ADDR_VALID_BITS] != 0 is a range error.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 of the load/store
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned, illegal funct3, or out-of-range
- dc_write_en  output  4  byte write enables to cache
- dc_addr  output  30  word address [31:2] to cache
- dc_in_data  output  32  lane-replicated store data to cache
- dc_out_data  input  32  cache read data, valid one cycle after address edge

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - resp_valid, resp_err, resp_rdata, dc_write_en, dc_addr, dc_in_data = 0.
  - req_ready = 0 while rst is high.
  - An in-flight access is abandoned. dc_write_en falls immediately, so no write occurs at the next edge.
- States: IDLE, ACCESS, WAIT, RESP. req_ready = 1 only in IDLE with rst low.
- IDLE: on req_valid & req_ready, latch addr, we, funct3, shifted wdata, byte enables, and error.
  - No error: go to ACCESS.
  - Error: go to RESP with resp_err=1, resp_rdata=0. The cache is never touched.
- Error conditions:
  - Load funct3 in {011,110,111}.
  - Store funct3 >= 011.
  - LH/LHU/SH with addr[0] = 1.
  - LW/SW with addr[1:0] != 0.
  - Range violation.
- ACCESS (one cycle):
  - dc_addr = latched addr[31:2].
  - dc_write_en = latched byte enables for stores, 0000 for loads.
  - Store: go to RESP. Load: go to WAIT.
- dc_write_en is nonzero only in ACCESS. dc_addr and dc_in_data hold their latched values in all other states.
- Store lanes (k = addr[1:0]):
  - SB: dc_in_data = {4{wdata[7:0]}}, enables = 0001<<k.
  - SH: dc_in_data = {2{wdata[15:0]}}, enables = 0011<<k.
  - SW: dc_in_data = wdata, enables = 1111.
- WAIT (one cycle): dc_out_data is valid. Shift it right by 8*k, then extend:
  - LB: sign-extend bit 7.
  - LBU: zero-extend bits [7:0].
  - LH: sign-extend bit 15.
  - LHU: zero-extend bits [15:0].
  - LW: unchanged.
  - Register the result into resp_rdata and go to RESP.
- RESP: resp_valid = 1. resp_rdata and resp_err are held stable until resp_valid & resp_ready, then go to IDLE. There is no same-cycle re-accept.
- Latency, counted from the accept edge E:
  - Store: resp_valid from cycle E+2.
  - Load: resp_valid from cycle E+3.
  - Error: resp_valid from cycle E+1.
  - With resp_ready held high, minimum request period is 3/4/2 cycles respectively.
- resp_rdata = 0 for stores and errors.
- req_* inputs are ignored outside IDLE.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> in ACCESS: dc_addr = 0x4, dc_write_en = 1111, dc_in_data = 0xDEADBEEF; resp_valid 2 cycles after accept; resp_err = 0, resp_rdata = 0.
- SB addr 0x13, wdata 0xA5 -> dc_write_en = 1000, dc_in_data = 0xA5A5A5A5. Then LB 0x13 with dc_out_data = 0xA5000000 -> resp_rdata = 0xFFFFFFA5, 3 cycles after accept. LBU on the same data -> 0x000000A5.
- LH 0x12 with dc_out_data = 0x80011234 -> 0xFFFF8001. LHU -> 0x00008001. LW 0x12 -> resp_err = 1.
- Error cases, each giving resp_valid 1 cycle after accept, resp_err = 1, resp_rdata = 0, dc_write_en never nonzero:
  - LW 0x6
  - SH 0x1
  - SW 0x00010000 (range)
  - store with funct3 = 100
- Backpressure: hold resp_ready = 0 for 5 cycles after a load -> resp_valid, resp_rdata, resp_err stable, req_ready = 0, and a pending req_valid is not accepted. Release -> IDLE next cycle, new request accepted.
- Assert rst during the ACCESS cycle of an SW -> dc_write_en = 0 combinationally, no cache write at the edge, resp_valid = 0. After rst falls, req_ready = 1 and state is IDLE.

Source files
------------

// File: rtl/dcache_access_master.sv
// MEM-stage load/store requester for the data cache: aligns stores onto byte
// lanes, extends loads, and returns data or an error over a valid/ready response.
module dcache_access_master #(
  parameter int ADDR_VALID_BITS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  dc_write_en,
  output logic [29:0] dc_addr,
  output logic [31:0] dc_in_data,
  input  logic [31:0] dc_out_data
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] k;
  } req_t;

  state_t state;
  req_t   cur;

  logic                      acc_err;
  logic [3:0]                acc_be;
  logic [NUM_LANES-1:0][7:0] wlane;
  logic [31:0]               shifted;
  logic [31:0]               ld_data;

  // funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    logic bad_f, misal, range_err;
    bad_f     = req_we ? (req_funct3 >= 3'b011)
                       : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    misal     = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    range_err = (req_addr >> ADDR_VALID_BITS) != 32'd0;
    acc_err   = bad_f | misal | range_err;
    case (req_funct3[1:0])
      2'b00:   acc_be = 4'b0001 << req_addr[1:0];
      2'b01:   acc_be = 4'b0011 << req_addr[1:0];
      default: acc_be = 4'b1111;
    endcase
  end

  // Replicate store data so the enabled lanes always see the right bytes.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wlane[l] = (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
                      (req_funct3[1:0] == 2'b01) ? req_wdata[8*(l%2) +: 8] :
                                                   req_wdata[8*l +: 8];
  end

  always_comb begin
    shifted = dc_out_data >> {cur.k, 3'b000};
    case (cur.funct3)
      3'b000:  ld_data = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= 32'd0;
      dc_write_en <= 4'd0;
      dc_addr     <= 30'd0;
      dc_in_data  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cur.we     <= req_we;
          cur.funct3 <= req_funct3;
          cur.k      <= req_addr[1:0];
          resp_rdata <= 32'd0;
          resp_err   <= acc_err;
          if (acc_err) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            dc_addr     <= req_addr[31:2];
            dc_in_data  <= wlane;
            dc_write_en <= req_we ? acc_be : 4'd0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          dc_write_en <= 4'd0;
          if (cur.we) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          resp_rdata <= ld_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_access_master.sv
// Random + directed bench for dcache_access_master against a byte-level memory model.
module tb_dcache_access_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  dc_write_en;
  logic [29:0] dc_addr;
  logic [31:0] dc_in_data, dc_out_data;

  int errs = 0;
  int checks = 0;

  logic [31:0] cmem [0:63];
  logic [7:0]  rmem [0:255];

  always #5 clk = ~clk;

  dcache_access_master #(.ADDR_VALID_BITS(14)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dc_write_en(dc_write_en), .dc_addr(dc_addr),
    .dc_in_data(dc_in_data), .dc_out_data(dc_out_data)
  );

  // Cache stand-in: byte-enabled write and registered read at each edge.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dc_write_en[b]) cmem[dc_addr[5:0]][8*b +: 8] <= dc_in_data[8*b +: 8];
    dc_out_data <= cmem[dc_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input logic pend);
    int size, lat, n, seen, waitc;
    logic err;
    logic [3:0] e_be, c_be;
    logic [31:0] e_din, e_rd, c_din, rd0;
    logic [29:0] c_addr;
    logic err0;
    size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    err  = (we ? (f > 3'd2) : (f == 3'd3 || f > 3'd5)) || (addr % size != 0) ||
           (addr >= 32'h4000);
    lat  = err ? 1 : (we ? 2 : 3);
    e_be = 4'((1 << size) - 1) << (addr % 4);
    e_din = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
    e_rd = 32'd0;
    if (!err && !we) begin
      for (int i = 0; i < size; i++) e_rd |= 32'(rmem[addr + i]) << (8*i);
      if (!f[2] && size < 4 && e_rd[8*size-1]) e_rd |= ~((32'd1 << (8*size)) - 1);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f; req_addr = addr; req_wdata = wdata;
    waitc = 0;
    while (!req_ready && waitc < 10) begin @(negedge clk); waitc++; end
    chk("accept_wait", 32'(waitc < 10), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_funct3 = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    n = 0; seen = 0; c_be = 0; c_addr = 0; c_din = 0;
    do begin
      @(negedge clk); n++;
      if (dc_write_en != 4'd0) begin
        seen++; c_be = dc_write_en; c_addr = dc_addr; c_din = dc_in_data;
      end
    end while (!resp_valid && n < 10);
    chk("latency", n, lat);
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("resp_rdata", resp_rdata, e_rd);
    if (we && !err) begin
      chk("write_cycles", seen, 1);
      chk("write_en", 32'(c_be), 32'(e_be));
      chk("dc_addr", 32'(c_addr), 32'(addr[31:2]));
      chk("dc_in_data", c_din, e_din);
      for (int i = 0; i < size; i++) rmem[addr + i] = wdata[8*i +: 8];
    end else begin
      chk("no_write", seen, 0);
    end
    rd0 = resp_rdata; err0 = resp_err;
    if (pend) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = $urandom;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, rd0);
      chk("hold_err", 32'(resp_err), 32'(err0));
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_nowrite", 32'(dc_write_en), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] r, saved;
    rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0;
    for (int w = 0; w < 64; w++) begin
      r = $urandom; cmem[w] = r;
      for (int b = 0; b < 4; b++) rmem[4*w + b] = r[8*b +: 8];
    end
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_write_en", 32'(dc_write_en), 32'd0);
    chk("rst_dc_addr", 32'(dc_addr), 32'd0);
    chk("rst_dc_in_data", dc_in_data, 32'd0);
    chk("rst_resp", {resp_rdata[30:0], resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
    do_req(1, 3'b000, 32'h13, 32'h000000A5, 0, 0);
    do_req(0, 3'b000, 32'h13, 32'h0, 0, 0);
    do_req(0, 3'b100, 32'h13, 32'h0, 0, 0);
    do_req(1, 3'b010, 32'h10, 32'h80011234, 0, 0);
    do_req(0, 3'b001, 32'h12, 32'h0, 0, 0);
    do_req(0, 3'b101, 32'h12, 32'h0, 0, 0);
    do_req(0, 3'b010, 32'h12, 32'h0, 0, 0);
    do_req(0, 3'b010, 32'h6, 32'h0, 0, 0);
    do_req(1, 3'b001, 32'h1, 32'h1234, 0, 0);
    do_req(1, 3'b010, 32'h00010000, 32'h55, 0, 0);
    do_req(1, 3'b100, 32'h4, 32'h55, 0, 0);
    do_req(0, 3'b010, 32'h10, 32'h0, 5, 1);
    do_req(0, 3'b010, 32'h20, 32'h0, 0, 0);

    // Reset during the ACCESS cycle of a store: no write may land.
    saved = cmem[8];
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = ~saved;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rst_mid_we_before", 32'(dc_write_en), 32'hF);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_we", 32'(dc_write_en), 32'd0);
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_mem", cmem[8], saved);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_mid_idle", 32'(req_ready), 32'd1);
    do_req(0, 3'b010, 32'h20, 32'h0, 0, 0);

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 15) == 0) a |= 32'h1 << $urandom_range(14, 31);
      do_req(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
